// File: rtl/gauss5_window_ctrl.sv
// rtl/gauss5_window_ctrl.sv - frame FSM and 5x5 window builder behind the 5-row line buffer
// Optional WIN_COORD_EN adds win_row/win_col centre-coordinate outputs.
module gauss5_window_ctrl #(
    parameter int PIC_WIDTH  = 250,
    parameter int PIC_HEIGHT = 250,
    parameter int WIDTH      = 24,
    parameter int RST_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     pix_in,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    output logic                 lb_rst_fifo,
    input  logic                 lb_fifo_rst_busy,
    output logic [WIDTH-1:0]     lb_din,
    output logic                 lb_valid_in,
    output logic                 lb_rd_en_all,
    input  logic [WIDTH-1:0]     lb_dout1,
    input  logic [WIDTH-1:0]     lb_dout2,
    input  logic [WIDTH-1:0]     lb_dout3,
    input  logic [WIDTH-1:0]     lb_dout4,
    input  logic [WIDTH-1:0]     lb_dout5,
    output logic [25*WIDTH-1:0]  win,
    output logic                 win_valid,
`ifdef WIN_COORD_EN
    output logic [15:0]          win_row,
    output logic [15:0]          win_col,
`endif
    output logic                 frame_done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FRST  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;

    localparam logic [15:0] COL_LAST = 16'(PIC_WIDTH - 1);
    localparam logic [15:0] ROW_LAST = 16'(PIC_HEIGHT - 1);
    localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);

    logic [2:0]       state;
    logic [15:0]      col_cnt;
    logic [15:0]      row_cnt;
    logic [15:0]      rst_cnt;
    logic             accept;
    logic             rd_en;
    logic             col_last;
    logic [WIDTH-1:0] dcol [5];

    assign pix_ready    = (state == S_RUN);
    assign accept       = pix_valid && pix_ready;
    assign lb_din       = pix_ready ? pix_in : '0;
    assign lb_valid_in  = accept;
    assign lb_rst_fifo  = (state != S_FRST);
    assign col_last     = (col_cnt == COL_LAST);
    // The fifos hold five complete rows only once row 5 starts arriving.
    assign rd_en        = (accept && (row_cnt >= 16'd5)) || (state == S_FLUSH);
    assign lb_rd_en_all = rd_en;
    assign frame_done   = (state == S_FLUSH) && col_last;

    // Window row 0 is the oldest line (dout5), row 4 the newest (dout1).
    assign dcol[0] = lb_dout5;
    assign dcol[1] = lb_dout4;
    assign dcol[2] = lb_dout3;
    assign dcol[3] = lb_dout2;
    assign dcol[4] = lb_dout1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            col_cnt <= '0;
            row_cnt <= '0;
            rst_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_FRST;
                        rst_cnt <= '0;
                        col_cnt <= '0;
                        row_cnt <= '0;
                    end
                end
                S_FRST: begin
                    if (rst_cnt == RST_LAST) state <= S_WAIT;
                    else                     rst_cnt <= rst_cnt + 16'd1;
                end
                S_WAIT: begin
                    if (!lb_fifo_rst_busy) state <= S_RUN;
                end
                S_RUN: begin
                    if (accept) begin
                        if (col_last) begin
                            col_cnt <= '0;
                            if (row_cnt == ROW_LAST) state <= S_FLUSH;
                            else                     row_cnt <= row_cnt + 16'd1;
                        end else begin
                            col_cnt <= col_cnt + 16'd1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (col_last) begin
                        col_cnt <= '0;
                        state   <= S_IDLE;
                    end else begin
                        col_cnt <= col_cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win       <= '0;
            win_valid <= 1'b0;
`ifdef WIN_COORD_EN
            win_row   <= '0;
            win_col   <= '0;
`endif
        end else begin
            win_valid <= rd_en && (col_cnt >= 16'd4);
            if (rd_en) begin
                for (int r = 0; r < 5; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        win[WIDTH*(5*r+c) +: WIDTH] <= win[WIDTH*(5*r+c+1) +: WIDTH];
                    end
                    win[WIDTH*(5*r+4) +: WIDTH] <= dcol[r];
                end
            end
`ifdef WIN_COORD_EN
            if (rd_en && (col_cnt >= 16'd4)) begin
                win_row <= (state == S_FLUSH) ? 16'(PIC_HEIGHT - 3) : row_cnt - 16'd3;
                win_col <= col_cnt - 16'd2;
            end
`endif
        end
    end

endmodule

// File: tb/tb_gauss5_window_ctrl.sv
// tb/tb_gauss5_window_ctrl.sv - scoreboard bench for gauss5_window_ctrl with a line buffer model
// Build with WIN_COORD_EN defined to also check win_row/win_col.
module tb_gauss5_window_ctrl;

    localparam int W         = 8;
    localparam int H         = 6;
    localparam int PW        = 24;
    localparam int RC        = 8;
    localparam int BUSY_TAIL = 12;
    localparam int WINW      = 25*PW;

    logic            clk = 1'b0;
    logic            rst_n, start, pix_valid;
    logic [PW-1:0]   pix_in;
    logic            pix_ready, lb_rst_fifo, lb_fifo_rst_busy;
    logic [PW-1:0]   lb_din;
    logic            lb_valid_in, lb_rd_en_all;
    logic [PW-1:0]   dq [5];
    logic [WINW-1:0] win;
    logic            win_valid, frame_done;
`ifdef WIN_COORD_EN
    logic [15:0]     win_row, win_col;
`endif

    gauss5_window_ctrl #(.PIC_WIDTH(W), .PIC_HEIGHT(H), .WIDTH(PW), .RST_CYCLES(RC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .lb_rst_fifo(lb_rst_fifo), .lb_fifo_rst_busy(lb_fifo_rst_busy),
        .lb_din(lb_din), .lb_valid_in(lb_valid_in), .lb_rd_en_all(lb_rd_en_all),
        .lb_dout1(dq[0]), .lb_dout2(dq[1]), .lb_dout3(dq[2]), .lb_dout4(dq[3]), .lb_dout5(dq[4]),
        .win(win), .win_valid(win_valid),
`ifdef WIN_COORD_EN
        .win_row(win_row), .win_col(win_col),
`endif
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Show-ahead 5-row line buffer model: reads return the five rows preceding the read row.
    logic [PW-1:0] mem [H][W];
    int wr_r = 0, wr_c = 0, rd_r = 0, rd_c = 0, busy_cnt = 0;

    assign lb_fifo_rst_busy = !lb_rst_fifo || (busy_cnt > 0);

    always @(posedge clk) begin
        if (!lb_rst_fifo) begin
            wr_r <= 0; wr_c <= 0; rd_r <= 0; rd_c <= 0;
            busy_cnt <= BUSY_TAIL;
        end else begin
            if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
            if (lb_valid_in) begin
                if (wr_r < H) mem[wr_r][wr_c] <= lb_din;
                if (wr_c == W-1) begin wr_c <= 0; wr_r <= wr_r + 1; end
                else wr_c <= wr_c + 1;
            end
            if (lb_rd_en_all) begin
                if (rd_c == W-1) begin rd_c <= 0; rd_r <= rd_r + 1; end
                else rd_c <= rd_c + 1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 5; k++) begin
            dq[k] = '0;
            if (rd_r + 4 - k < H) dq[k] = mem[rd_r + 4 - k][rd_c];
        end
    end

    typedef struct {
        logic [WINW-1:0] w;
        logic [15:0]     row;
        logic [15:0]     col;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0, n_fail = 0, n_win = 0;
    bit   chk_first = 0;

    task automatic check(input string tag, input logic [WINW-1:0] obs, input logic [WINW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] px(input logic [PW-1:0] base, input int r, input int c);
        return base + PW'((r << 8) | c);
    endfunction

    task automatic push_frame(input logic [PW-1:0] base);
        exp_t e;
        for (int cr = 2; cr <= H-3; cr++) begin
            for (int cc = 2; cc <= W-3; cc++) begin
                for (int r = 0; r < 5; r++)
                    for (int c = 0; c < 5; c++)
                        e.w[PW*(5*r+c) +: PW] = px(base, cr-2+r, cc-2+c);
                e.row = 16'(cr);
                e.col = 16'(cc);
                sb.push_back(e);
            end
        end
    endtask

    logic            rd_prev = 1'b0, rstn_prev = 1'b0;
    logic [WINW-1:0] win_last = '0;

    always @(posedge clk) rd_prev <= rst_n && lb_rd_en_all;

    always @(negedge clk) begin
        if (rst_n) begin
            if (win_valid) begin
                exp_t e;
                check("win_valid_after_read", WINW'(rd_prev), WINW'(1));
                check("sb_nonempty", WINW'(sb.size() > 0), WINW'(1));
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("win", win, e.w);
`ifdef WIN_COORD_EN
                    check("win_row", WINW'(win_row), WINW'(e.row));
                    check("win_col", WINW'(win_col), WINW'(e.col));
`endif
                end
                if (n_win == 0 && chk_first) begin
                    check("first_win_top_left", WINW'(win[PW*0 +: PW]), WINW'(24'h000000));
                    check("first_win_bot_right", WINW'(win[PW*24 +: PW]), WINW'(24'h000404));
                end
                n_win <= n_win + 1;
            end else if (rstn_prev && !rd_prev) begin
                check("win_hold_idle", win, win_last);
            end
        end
        win_last  <= win;
        rstn_prev <= rst_n;
    end

    task automatic check_reset_values();
        check("rst_pix_ready", WINW'(pix_ready), WINW'(0));
        check("rst_lb_rst_fifo", WINW'(lb_rst_fifo), WINW'(1));
        check("rst_win_valid", WINW'(win_valid), WINW'(0));
        check("rst_frame_done", WINW'(frame_done), WINW'(0));
        check("rst_lb_rd_en_all", WINW'(lb_rd_en_all), WINW'(0));
        check("rst_lb_valid_in", WINW'(lb_valid_in), WINW'(0));
        check("rst_lb_din", WINW'(lb_din), WINW'(0));
    endtask

    task automatic run_frame(input logic [PW-1:0] base, input bit toggle, input int abort_at);
        int idx, cyc, rst_low, bud, fd;
        bit prev_b, prev2_b, acc;
        push_frame(base);
        chk_first = (base == '0);
        n_win = 0;
        pix_valid = 1'b1;
        pix_in = px(base, 0, 0);
        #1;
        check("idle_no_accept", WINW'(lb_valid_in), WINW'(0));
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; pix_valid = 1'b0;
        rst_low = 0; prev_b = 0; prev2_b = 0; bud = 0;
        while (!pix_ready && bud < 200) begin
            if (!lb_rst_fifo) rst_low++;
            prev2_b = prev_b;
            prev_b = lb_fifo_rst_busy;
            @(negedge clk);
            bud++;
        end
        check("run_reached", WINW'(pix_ready), WINW'(1));
        check("rst_fifo_low_cycles", WINW'(rst_low), WINW'(RC));
        check("run_after_busy_fall", WINW'({prev2_b, prev_b}), WINW'(2'b10));
        idx = 0; cyc = 0;
        while (idx < W*H && cyc < 2000) begin
            pix_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            pix_in = px(base, idx / W, idx % W);
            start = (idx == 20);
            if (idx == abort_at) begin
                rst_n = 1'b0; pix_valid = 1'b0; start = 1'b0;
                #1;
                check_reset_values();
                @(negedge clk); rst_n = 1'b1;
                sb.delete();
                return;
            end
            #1;
            acc = pix_valid && pix_ready;
            @(negedge clk);
            if (acc) idx++;
            cyc++;
        end
        pix_valid = 1'b0; start = 1'b0;
        check("all_pixels_accepted", WINW'(idx), WINW'(W*H));
        fd = 0;
        for (int i = 0; i < 4*W; i++) begin
            if (frame_done) fd++;
            @(negedge clk);
        end
        check("frame_done_pulses", WINW'(fd), WINW'(1));
        check("windows_per_frame", WINW'(n_win), WINW'((W-4)*(H-4)));
        check("sb_drained", WINW'(sb.size()), WINW'(0));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_in = '0;
        repeat (3) @(negedge clk);
        check_reset_values();
        check("rst_win", win, '0);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(24'h000000, 1'b0, -1);
        run_frame(24'h000000, 1'b1, -1);
        run_frame(24'h010000, 1'b0, 3*W + 4);
        run_frame(24'h010000, 1'b0, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
